mmig_serial_adder: RTL and testbench

MMIG_SERIAL_ADDER -- requirements
Module: mmig_serial_adder

---
 rtl/mmig_serial_adder.sv | 152 +++++++++++++++
 tb/tb_mmig_serial_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmig_serial_adder.sv
// mmig_serial_adder: digit-serial adder/subtractor for SPECK-style words.
// One DIGIT-bit slice is processed per clock through a ripple chain of
// majority-logic full adders. Subtraction is a + ~b + 1: the operand is
// inverted at capture and the carry register is seeded with 1.
//
// Handshake: start is a request that is only looked at in IDLE; there is no
// ready signal, and busy=1 means any start is ignored. done is a one-cycle
// pulse in the DONE state. sum/cout hold from done until the next accepted
// start.
module mmig_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // DIGIT_SAFE keeps the arithmetic below legal while the error fires.
  localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int D          = WIDTH / DIGIT_SAFE;
  localparam int CW         = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_bad_cfg
      $error("mmig_serial_adder: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
    end
  endgenerate

  // State is kept as a named enum so r_state can be probed by name.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_carry;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_sum;
  logic                  r_cout;

  int                    w_base;
  logic                  w_last;
  logic [DIGIT_SAFE:0]   w_dig;
  logic [DIGIT_SAFE-1:0] w_dsum;
  logic                  w_dcarry;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Ripple chain of full adders. Carry is the majority; sum uses the
  // identity x^y^c = maj(~maj(x,y,c), c, maj(x,y,~c)).
  function automatic logic [DIGIT_SAFE:0] digit_add(
    input logic [DIGIT_SAFE-1:0] x,
    input logic [DIGIT_SAFE-1:0] y,
    input logic                  cin
  );
    logic                  c;
    logic                  m;
    logic [DIGIT_SAFE-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT_SAFE; i++) begin
      m    = maj3(x[i], y[i], c);
      s[i] = maj3(~m, c, maj3(x[i], y[i], ~c));
      c    = m;
    end
    return {c, s};
  endfunction

  assign w_base   = int'(r_cnt) * DIGIT_SAFE;
  assign w_last   = (r_cnt == LAST);
  assign w_dig    = digit_add(r_a[w_base +: DIGIT_SAFE], r_b[w_base +: DIGIT_SAFE], r_carry);
  assign w_dsum   = w_dig[DIGIT_SAFE-1:0];
  assign w_dcarry = w_dig[DIGIT_SAFE];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last digit,
  // DONE -> IDLE unconditionally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, then one digit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= mode ? ~b : b;
            r_carry <= mode;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: DIGIT_SAFE] <= w_dsum;
          r_carry                     <= w_dcarry;
          if (w_last) r_cout <= w_dcarry;
          else        r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_mmig_serial_adder.sv
// Bench for mmig_serial_adder: three instances at WIDTH=16 with DIGIT=4, 1
// and 16 share the same stimulus; results are checked against modular
// arithmetic computed in the bench.
module tb_mmig_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         busy4, done4, cout4;
  logic [W-1:0] sum4;
  logic         busy1, done1, cout1;
  logic [W-1:0] sum1;
  logic         busy16, done16, cout16;
  logic [W-1:0] sum16;

  int total = 0;
  int bad   = 0;

  // expected {cout, sum} for the DIGIT=4 instance
  logic [W:0] exp_q[$];

  mmig_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  mmig_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  mmig_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, sum}; in subtract mode cout = 1 means no borrow (a >= b).
  function automatic logic [W:0] model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                       input logic om);
    logic [W:0] wide;
    if (om) begin
      wide = {1'b0, oa} - {1'b0, ob};
      return {~wide[W], wide[W-1:0]};
    end
    wide = {1'b0, oa} + {1'b0, ob};
    return wide;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy4, done4, cout4, sum4} !== '0) begin
      bad++;
      $display("FAIL reset_d4: got busy=%b done=%b cout=%b sum=%h want all 0",
               busy4, done4, cout4, sum4);
    end
    total++;
    if ({busy1, done1, cout1, sum1, busy16, done16, cout16, sum16} !== '0) begin
      bad++;
      $display("FAIL reset_others: got d1 %b%b%b %h d16 %b%b%b %h want all 0",
               busy1, done1, cout1, sum1, busy16, done16, cout16, sum16);
    end
    rst = 1'b0;
  endtask

  // Launch one operation on all instances, scramble inputs after acceptance,
  // then observe 18 cycles (edge k .. edge k+17) and check every instance.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic om,
                        input string tag);
    logic [W:0]   exp_v;
    logic [W:0]   exp4;
    int           lat4, lat1, lat16, cnt4, cnt1, cnt16;
    logic [W-1:0] s4, s1, s16;
    logic         c4, c1, c16;
    exp_v = model(oa, ob, om);
    exp_q.push_back(exp_v);
    lat4 = -1; lat1 = -1; lat16 = -1;
    cnt4 = 0;  cnt1 = 0;  cnt16 = 0;
    s4 = '0; s1 = '0; s16 = '0; c4 = 0; c1 = 0; c16 = 0;
    @(negedge clk);
    a = oa; b = ob; mode = om; start = 1'b1;
    for (int n = 0; n <= W + 1; n++) begin
      @(negedge clk);
      if (n == 0) begin
        total++;
        if ({busy4, busy1, busy16} !== 3'b111) begin
          bad++;
          $display("FAIL %s accept_busy: got %b want 111", tag, {busy4, busy1, busy16});
        end
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        mode  = 1'($urandom);
      end
      if (done4 === 1'b1) begin
        cnt4++;
        if (lat4 < 0) begin lat4 = n; s4 = sum4; c4 = cout4; end
      end
      if (done1 === 1'b1) begin
        cnt1++;
        if (lat1 < 0) begin lat1 = n; s1 = sum1; c1 = cout1; end
      end
      if (done16 === 1'b1) begin
        cnt16++;
        if (lat16 < 0) begin lat16 = n; s16 = sum16; c16 = cout16; end
      end
      total++;
      if (busy4 !== (n <= 4)) begin
        bad++;
        $display("FAIL %s busy_d4 cycle %0d: got %b want %b", tag, n, busy4, (n <= 4));
      end
    end
    exp4 = exp_q.pop_front();
    total++;
    if ({lat4, lat1, lat16} !== {32'sd4, 32'sd16, 32'sd1}) begin
      bad++;
      $display("FAIL %s latency: got d4=%0d d1=%0d d16=%0d want 4 16 1", tag, lat4, lat1, lat16);
    end
    total++;
    if ({cnt4, cnt1, cnt16} !== {32'sd1, 32'sd1, 32'sd1}) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d %0d %0d want 1 1 1", tag, cnt4, cnt1, cnt16);
    end
    total++;
    if ({c4, s4} !== exp4) begin
      bad++;
      $display("FAIL %s result_d4: got cout=%b sum=%h want cout=%b sum=%h",
               tag, c4, s4, exp4[W], exp4[W-1:0]);
    end
    total++;
    if ({c1, s1} !== exp_v) begin
      bad++;
      $display("FAIL %s result_d1: got cout=%b sum=%h want cout=%b sum=%h",
               tag, c1, s1, exp_v[W], exp_v[W-1:0]);
    end
    total++;
    if ({c16, s16} !== exp_v) begin
      bad++;
      $display("FAIL %s result_d16: got cout=%b sum=%h want cout=%b sum=%h",
               tag, c16, s16, exp_v[W], exp_v[W-1:0]);
    end
    total++;
    if ({cout4, sum4} !== exp4) begin
      bad++;
      $display("FAIL %s hold_d4: got cout=%b sum=%h want cout=%b sum=%h",
               tag, cout4, sum4, exp4[W], exp4[W-1:0]);
    end
  endtask

  task automatic test_add_wrap();
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
  endtask

  task automatic test_subtract();
    run_op(16'h0000, 16'h0001, 1'b1, "sub_borrow");
    run_op(16'h1234, 16'h0234, 1'b1, "sub_noborrow");
    run_op(16'h8000, 16'h8000, 1'b1, "sub_equal");
  endtask

  // start held high with changing operands for the whole RUN and DONE span.
  task automatic test_busy_protect();
    logic [W:0] exp_v;
    int         dcnt;
    int         dlat;
    logic [W:0] got;
    exp_v = model(16'hA5C3, 16'h3C5A, 1'b0);
    dcnt = 0;
    dlat = -1;
    got  = '0;
    @(negedge clk);
    a = 16'hA5C3; b = 16'h3C5A; mode = 1'b0; start = 1'b1;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        dcnt++;
        if (dlat < 0) begin dlat = n; got = {cout4, sum4}; end
      end
      a    = W'($urandom);
      b    = W'($urandom);
      mode = 1'($urandom);
      if (n == 5) start = 1'b0;
    end
    total++;
    if (dlat !== 4) begin
      bad++;
      $display("FAIL busy_latency: got %0d want 4", dlat);
    end
    total++;
    if (dcnt !== 1) begin
      bad++;
      $display("FAIL busy_done_pulses: got %0d want 1", dcnt);
    end
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL busy_result: got %h want %h", got, exp_v);
    end
    total++;
    if ({cout4, sum4} !== exp_v) begin
      bad++;
      $display("FAIL busy_hold: got %h want %h", {cout4, sum4}, exp_v);
    end
    repeat (20) @(negedge clk);
  endtask

  // Asynchronous reset between edges during RUN.
  task automatic test_reset_mid();
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1111; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy4, done4, cout4, sum4} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b cout=%b sum=%h want all 0",
               busy4, done4, cout4, sum4);
    end
    #1 rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((done4 | done1 | done16) === 1'b1) dcnt++;
    end
    total++;
    if (dcnt !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d pulses want 0", dcnt);
    end
    run_op(16'h7FFF, 16'h0001, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       begin ra = '1; rb = W'($urandom); end
        1:       begin ra = '0; rb = W'($urandom); end
        2:       begin ra = W'($urandom); rb = '1; end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      run_op(ra, rb, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_subtract();
    test_busy_protect();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
